// File: rtl/conv2_window_ctrl.sv
// conv2_window_ctrl: sequences the pool1 pixel stream into the 5x5 window
// line buffers, flags legal window positions to the conv-sum engine and
// presents each result with its output row/column tag and a frame-done pulse.
module conv2_window_ctrl #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned HEIGHT      = 12,
    parameter int unsigned FILTER_SIZE = 5,
    parameter int unsigned CALC_LAT    = 1,
    localparam int unsigned OUT_H      = HEIGHT - FILTER_SIZE + 1,
    localparam int unsigned OUT_W      = WIDTH - FILTER_SIZE + 1,
    localparam int unsigned ROW_W      = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int unsigned COL_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             buf_shift_en,
    output logic             win_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned R_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned C_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [R_W-1:0]   row_q, row_d;
    logic [C_W-1:0]   col_q, col_d;
    logic             pv_q [CALC_LAT];
    logic [ROW_W-1:0] pr_q [CALC_LAT];
    logic [COL_W-1:0] pc_q [CALC_LAT];
    logic             out_valid_q;
    logic [ROW_W-1:0] out_row_q;
    logic [COL_W-1:0] out_col_q;

    logic adv_c;
    logic stage_busy_c;
    logic pipe_any_c;
    logic hs_c;
    logic win_hit_c;
    logic last_px_c;

    // Handshake, pipeline occupancy and window legality decode
    always_comb begin
        adv_c        = !out_valid_q || out_ready;
        stage_busy_c = 1'b0;
        pipe_any_c   = 1'b0;
        for (int k = 0; k < int'(CALC_LAT); k++) begin
            pipe_any_c = pipe_any_c | pv_q[k];
            if (k < int'(CALC_LAT) - 1) begin
                stage_busy_c = stage_busy_c | pv_q[k];
            end
        end
        in_ready     = (state_q == RUN) && !stage_busy_c && adv_c;
        hs_c         = in_valid && in_ready;
        buf_shift_en = hs_c;
        win_hit_c    = hs_c && (row_q >= R_W'(FILTER_SIZE - 1))
                            && (col_q >= C_W'(FILTER_SIZE - 1));
        last_px_c    = (row_q == R_W'(HEIGHT - 1)) && (col_q == C_W'(WIDTH - 1));
    end

    // Next-state and raster counter update
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (hs_c) begin
                    if (col_q == C_W'(WIDTH - 1)) begin
                        col_d = '0;
                        row_d = last_px_c ? '0 : row_q + R_W'(1);
                    end else begin
                        col_d = col_q + C_W'(1);
                    end
                    if (last_px_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pipe_any_c && adv_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Window/result pipeline; the whole chain freezes while the output is held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(CALC_LAT); k++) begin
                pv_q[k] <= 1'b0;
                pr_q[k] <= '0;
                pc_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else if (adv_c) begin
            pv_q[0] <= win_hit_c;
            pr_q[0] <= ROW_W'(row_q - R_W'(FILTER_SIZE - 1));
            pc_q[0] <= COL_W'(col_q - C_W'(FILTER_SIZE - 1));
            for (int k = 1; k < int'(CALC_LAT); k++) begin
                pv_q[k] <= pv_q[k-1];
                pr_q[k] <= pr_q[k-1];
                pc_q[k] <= pc_q[k-1];
            end
            out_valid_q <= pv_q[CALC_LAT-1];
            if (pv_q[CALC_LAT-1]) begin
                out_row_q <= pr_q[CALC_LAT-1];
                out_col_q <= pc_q[CALC_LAT-1];
            end
        end
    end

    assign win_valid  = pv_q[0];
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

// File: doc/conv2_window_ctrl.md
Name: conv2_window_ctrl

Overview:
- Sequencing controller for the 2nd convolution layer datapath.
- Accepts the pool1 feature-map pixel stream (3 channels in parallel, one beat per pixel position) with a valid/ready handshake.
- Drives the 5x5 window line-buffer shift enable and tells the convolution-sum engine when the buffered window is a legal output position.
- Presents each result with valid/ready, its output row/column tag, and a frame-done pulse.

Parameters:
- WIDTH, 12, input feature-map width in pixels.
- HEIGHT, 12, input feature-map height in pixels.
- FILTER_SIZE, 5, square kernel size.
- CALC_LAT, 1, cycles from window capture to calc result registered downstream (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- in_valid  in  1  upstream pixel beat valid.
- in_ready  out  1  controller accepts a beat this cycle.
- buf_shift_en  out  1  advance the window line buffers (= in_valid & in_ready, combinational).
- win_valid  out  1  registered pulse: buffer holds a legal window; calc samples it.
- out_valid  out  1  result valid (CALC_LAT cycles after win_valid), held until taken.
- out_ready  in  1  downstream accepts the result.
- out_row  out  $clog2(HEIGHT-FILTER_SIZE+1)  output row of the presented result (default 3 bits, 0..7).
- out_col  out  $clog2(WIDTH-FILTER_SIZE+1)  output column of the presented result (default 3 bits).
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the last result is taken.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - row/col counters, pipeline valid bits, win_valid, out_valid, out_row, out_col and frame_done all clear to 0.
  - in_ready=0, busy=0.
  - Reset mid-frame abandons the frame with no frame_done.
- FSM:
  - IDLE: start=1 -> RUN and counters clear. Otherwise stay. in_ready=0.
  - RUN: accept beats. Accepting the pixel at (HEIGHT-1, WIDTH-1) -> DRAIN.
  - DRAIN: in_ready=0. When no pipeline bits are set and out_valid=0 (or the last result is taken this cycle) -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
  - start is ignored outside IDLE.
- Accept: handshake = in_valid & in_ready.
  - On a handshake, col increments. At WIDTH-1, col wraps to 0 and row increments.
  - Counters hold when there is no handshake, so gaps in in_valid are allowed.
- in_ready = (state==RUN) & (no window in pipeline stages 1..CALC_LAT-1) & (!out_valid | out_ready).
  - With CALC_LAT=1 this gives full throughput unless the output stalls.
  - Line buffers never shift while a window is unconsumed.
- Window legality: a handshake on pixel (r,c) with r>=FILTER_SIZE-1 and c>=FILTER_SIZE-1 sets win_valid=1 on the next cycle, tagged (r-4, c-4).
  - Column-wrap positions (c<4) and top rows (r<4) never produce win_valid.
- Result pipeline:
  - The win_valid bit and its tag shift through CALC_LAT registers.
  - On exit they load out_valid/out_row/out_col.
  - out_valid=1 with out_ready=0 holds out_valid and the tag stable.
  - A simultaneous take and new load replaces the result with no bubble.
- Count: each frame yields exactly (HEIGHT-4)*(WIDTH-4) = 64 results, in raster order.
- Simultaneous events: start arriving in DONE is ignored; IDLE is re-entered first and start must be reasserted.

Test Plan:
- Reset, then start=1 with in_valid held 1, out_ready=1, CALC_LAT=1, 144 beats -> exactly 64 out_valid pulses.
  - First pulse is (0,0), 1 cycle after the win_valid that follows beat index 52 (r=4,c=4). Last is (7,7).
  - frame_done fires once; busy returns to 0.
- Same stimulus, beats 0..143 -> no win_valid for any beat with c<4 or r<4; buf_shift_en count = 144.
- Hold out_ready=0 for 5 cycles when the result for (2,3) appears -> out_valid, out_row=2, out_col=3 stable.
  - in_ready=0 and buf_shift_en=0 throughout.
  - Stream resumes with no lost or duplicated tags.
- in_valid toggling 1/0 every cycle -> same 64 results and tags as the continuous run; counters hold during gaps.
- Assert rst_n=0 for 1 cycle after beat 80 -> all outputs 0 next cycle, no frame_done.
  - A new start then produces 64 fresh results beginning at (0,0).
- CALC_LAT=3, continuous input -> out_valid appears 3 cycles after each win_valid.
  - in_ready deasserts for 2 cycles after each window beat; 64 results total.
